// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver with wrong-path squash tracking.
// Optional feature: define BRANCH_STATS_EN to add br_count / br_taken_count.
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int PC_WORD_ADDR = 1,
    parameter int SQUASH_SLOTS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] pcD,
    input  logic [XLEN-1:0] pcplus4D,
    input  logic [XLEN-1:0] rs1D,
    input  logic [XLEN-1:0] rs2D,
    output logic            pcsrcE,
    output logic [XLEN-1:0] pctargetE,
    output logic            validE,
    output logic [XLEN-1:0] linkE,
    output logic [4:0]      rdE,
    output logic            linkwrE,
    output logic            misalignE
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     br_taken_count
`endif
);

    localparam int CW = $clog2(SQUASH_SLOTS + 1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0]     instrE;
    logic [XLEN-1:0] pcE, pcplus4E, rs1E, rs2E;
    logic [CW-1:0]   squashCnt;
    logic            outOfReset;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrE     <= '0;
            pcE        <= '0;
            pcplus4E   <= '0;
            rs1E       <= '0;
            rs2E       <= '0;
            outOfReset <= 1'b0;
        end else begin
            instrE     <= instrD;
            pcE        <= pcD;
            pcplus4E   <= pcplus4D;
            rs1E       <= rs1D;
            rs2E       <= rs2D;
            outOfReset <= 1'b1;
        end
    end

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            isBranch, isJal, isJalr;
    logic [XLEN-1:0] immB, immJ, immI;
    logic [XLEN-1:0] pcByte, jalrSum, byteTarget;
    logic            cond, taken;

    assign opcode   = instrE[6:0];
    assign funct3   = instrE[14:12];
    assign isBranch = (opcode == OP_BRANCH);
    assign isJal    = (opcode == OP_JAL);
    assign isJalr   = (opcode == OP_JALR);

    assign immB = {{(XLEN-12){instrE[31]}}, instrE[7], instrE[30:25], instrE[11:8], 1'b0};
    assign immJ = {{(XLEN-20){instrE[31]}}, instrE[19:12], instrE[20], instrE[30:21], 1'b0};
    assign immI = {{(XLEN-12){instrE[31]}}, instrE[31:20]};

    assign pcByte  = (PC_WORD_ADDR != 0) ? {pcE[XLEN-3:0], 2'b00} : pcE;
    assign jalrSum = rs1E + immI;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cond = 1'b0;
        if (isBranch) begin
            case (funct3)
                3'b000:  cond = (rs1E == rs2E);
                3'b001:  cond = (rs1E != rs2E);
                3'b100:  cond = ($signed(rs1E) <  $signed(rs2E));
                3'b101:  cond = ($signed(rs1E) >= $signed(rs2E));
                3'b110:  cond = (rs1E <  rs2E);
                3'b111:  cond = (rs1E >= rs2E);
                default: cond = 1'b0;
            endcase
        end else if (isJal || isJalr) begin
            cond = 1'b1;
        end
    end

    always_comb begin
        byteTarget = pcByte + immB;
        if (isJal)
            byteTarget = pcByte + immJ;
        else if (isJalr)
            byteTarget = {jalrSum[XLEN-1:1], 1'b0};
    end

    // Squashed or pre-reset slots are bubbles: they may not redirect, link or flag.
    assign validE    = (squashCnt == '0) && outOfReset;
    assign taken     = validE && cond;
    assign pcsrcE    = taken;
    assign misalignE = taken && (byteTarget[1:0] != 2'b00);
    assign linkE     = pcplus4E;
    assign rdE       = instrE[11:7];
    assign linkwrE   = validE && (isJal || isJalr) && (rdE != 5'd0);

    always_comb begin
        pctargetE = '0;
        if (taken)
            pctargetE = (PC_WORD_ADDR != 0) ? {2'b00, byteTarget[XLEN-1:2]} : byteTarget;
    end

    // Fetch has no flush, so the slots already in F and D arrive here as wrong-path work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            squashCnt <= '0;
        else if (taken)
            squashCnt <= CW'(SQUASH_SLOTS);
        else if (squashCnt != '0)
            squashCnt <= squashCnt - 1'b1;
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else begin
            if (validE && (isBranch || isJal || isJalr))
                br_count <= br_count + 32'd1;
            if (taken)
                br_taken_count <= br_taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (word-addressed PC, 2 squash slots).
module tb_branch_resolve_unit;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ8     = 32'h0020_8463;
    localparam logic [31:0] BLT8     = 32'h0020_C463;
    localparam logic [31:0] BLTU8    = 32'h0020_E463;
    localparam logic [31:0] JALR_RD1 = 32'h0040_80E7;
    localparam logic [31:0] JALR_RD0 = 32'h0040_8067;
    localparam logic [31:0] JAL8     = 32'h0080_00EF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD, pcD, pcplus4D, rs1D, rs2D;
    logic        pcsrcE, validE, linkwrE, misalignE;
    logic [31:0] pctargetE, linkE;
    logic [4:0]  rdE;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, br_taken_count;
`endif

    int errors = 0;
    int checks = 0;

    branch_resolve_unit #(.XLEN(32), .PC_WORD_ADDR(1), .SQUASH_SLOTS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .instrD    (instrD),
        .pcD       (pcD),
        .pcplus4D  (pcplus4D),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .pcsrcE    (pcsrcE),
        .pctargetE (pctargetE),
        .validE    (validE),
        .linkE     (linkE),
        .rdE       (rdE),
        .linkwrE   (linkwrE),
        .misalignE (misalignE)
`ifdef BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one instruction at the falling edge; return just after it lands in E.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instrD = ins; pcD = pc; pcplus4D = pc4; rs1D = a; rs2D = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        instrD = NOP; pcD = '0; pcplus4D = '0; rs1D = '0; rs2D = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",    {31'd0, validE},    32'd0);
        check("rst_pcsrc",    {31'd0, pcsrcE},    32'd0);
        check("rst_target",   pctargetE,          32'd0);
        check("rst_link",     linkE,              32'd0);
        check("rst_rd",       {27'd0, rdE},       32'd0);
        check("rst_linkwr",   {31'd0, linkwrE},   32'd0);
        check("rst_misalign", {31'd0, misalignE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, two squashed slots, then a live back-to-back taken BEQ
        step(BEQ8, 32'h10, 32'h11, 32'd5, 32'd5);
        check("beq_pcsrc",    {31'd0, pcsrcE},    32'd1);
        check("beq_target",   pctargetE,          32'h12);
        check("beq_valid",    {31'd0, validE},    32'd1);
        check("beq_misalign", {31'd0, misalignE}, 32'd0);
        step(BEQ8, 32'h11, 32'h12, 32'd5, 32'd5);
        check("sq1_valid",  {31'd0, validE}, 32'd0);
        check("sq1_pcsrc",  {31'd0, pcsrcE}, 32'd0);
        check("sq1_target", pctargetE,       32'd0);
        step(BEQ8, 32'h12, 32'h13, 32'd5, 32'd5);
        check("sq2_valid", {31'd0, validE}, 32'd0);
        step(BEQ8, 32'h13, 32'h14, 32'd5, 32'd5);
        check("b2b_valid",  {31'd0, validE}, 32'd1);
        check("b2b_pcsrc",  {31'd0, pcsrcE}, 32'd1);
        check("b2b_target", pctargetE,       32'h15);
        step(NOP, 32'h14, 32'h15, 32'd0, 32'd0);
        step(NOP, 32'h15, 32'h16, 32'd0, 32'd0);

        // BEQ not taken: no redirect and no bubble afterwards
        step(BEQ8, 32'h20, 32'h21, 32'd5, 32'd6);
        check("beqnt_pcsrc",  {31'd0, pcsrcE}, 32'd0);
        check("beqnt_target", pctargetE,       32'd0);
        step(NOP, 32'h21, 32'h22, 32'd0, 32'd0);
        check("beqnt_next_valid", {31'd0, validE}, 32'd1);

        // Signed vs unsigned less-than
        step(BLT8, 32'h30, 32'h31, 32'hFFFF_FFFF, 32'd1);
        check("blt_pcsrc",  {31'd0, pcsrcE}, 32'd1);
        check("blt_target", pctargetE,       32'h32);
        step(NOP, 32'h31, 32'h32, 32'd0, 32'd0);
        step(NOP, 32'h32, 32'h33, 32'd0, 32'd0);
        step(BLTU8, 32'h40, 32'h41, 32'hFFFF_FFFF, 32'd1);
        check("bltu_pcsrc", {31'd0, pcsrcE}, 32'd0);
        check("bltu_valid", {31'd0, validE}, 32'd1);
        step(NOP, 32'h41, 32'h42, 32'd0, 32'd0);
        check("bltu_next_valid", {31'd0, validE}, 32'd1);

        // JALR with odd base: bit0 cleared, byte target 0x106 misaligned
        step(JALR_RD1, 32'h20, 32'h21, 32'h103, 32'd0);
        check("jalr_pcsrc",    {31'd0, pcsrcE},    32'd1);
        check("jalr_target",   pctargetE,          32'h41);
        check("jalr_misalign", {31'd0, misalignE}, 32'd1);
        check("jalr_linkwr",   {31'd0, linkwrE},   32'd1);
        check("jalr_link",     linkE,              32'h21);
        check("jalr_rd",       {27'd0, rdE},       32'd1);
        step(NOP, 32'h41, 32'h42, 32'd0, 32'd0);
        step(NOP, 32'h42, 32'h43, 32'd0, 32'd0);
        step(JALR_RD0, 32'h50, 32'h51, 32'h103, 32'd0);
        check("jalr_x0_linkwr", {31'd0, linkwrE}, 32'd0);
        check("jalr_x0_pcsrc",  {31'd0, pcsrcE},  32'd1);
        step(NOP, 32'h41, 32'h42, 32'd0, 32'd0);
        step(NOP, 32'h42, 32'h43, 32'd0, 32'd0);

        // JAL wrap-around, then a wrong-path JAL that must not link or redirect
        step(JAL8, 32'h3FFF_FFFF, 32'h4000_0000, 32'd0, 32'd0);
        check("jal_wrap_target",   pctargetE,          32'h1);
        check("jal_wrap_misalign", {31'd0, misalignE}, 32'd0);
        check("jal_wrap_linkwr",   {31'd0, linkwrE},   32'd1);
        step(JAL8, 32'h4000_0000, 32'h4000_0001, 32'd0, 32'd0);
        check("jal_sq_linkwr", {31'd0, linkwrE}, 32'd0);
        check("jal_sq_pcsrc",  {31'd0, pcsrcE},  32'd0);
        step(NOP, 32'h1, 32'h2, 32'd0, 32'd0);

        // Asynchronous reset while two squash slots are pending
        step(BEQ8, 32'h10, 32'h11, 32'd5, 32'd5);
        step(BEQ8, 32'h11, 32'h12, 32'd5, 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_link",   linkE,              32'd0);
        check("arst_rd",     {27'd0, rdE},       32'd0);
        check("arst_valid",  {31'd0, validE},    32'd0);
        check("arst_target", pctargetE,          32'd0);
        @(negedge clk);
        instrD = NOP; pcD = 32'h1; pcplus4D = 32'h2;
        rst = 1'b0;
        #1;
        check("rel_first_valid", {31'd0, validE}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_next_valid", {31'd0, validE}, 32'd1);

`ifdef BRANCH_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(BEQ8, 32'h10, 32'h11, 32'd5, 32'd5);
        step(BEQ8, 32'h11, 32'h12, 32'd5, 32'd5);
        step(NOP, 32'h12, 32'h13, 32'd0, 32'd0);
        step(BLT8, 32'h30, 32'h31, 32'hFFFF_FFFF, 32'd1);
        step(NOP, 32'h31, 32'h32, 32'd0, 32'd0);
        step(NOP, 32'h32, 32'h33, 32'd0, 32'd0);
        step(BLTU8, 32'h40, 32'h41, 32'hFFFF_FFFF, 32'd1);
        step(NOP, 32'h41, 32'h42, 32'd0, 32'd0);
        check("stats_br_count", br_count,       32'd3);
        check("stats_br_taken", br_taken_count, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
